timer_seq_ctrl: RTL

TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

---
 rtl/timer_seq_pkg.sv | 31 +++
 rtl/timer_seq_ctrl_rise_detect.sv | 29 ++
 rtl/timer_seq_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/timer_seq_pkg.sv
// ============================================================================
// Module      : timer_seq_pkg
// Description : Shared states, timer register map and LOAD write count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ARM  = 3'd2,
        RUN  = 3'd3,
        STOP = 3'd4,
        FIN  = 3'd5
    } state_t;

    localparam logic [5:0] c_addr_ctrl   = 6'h00;
    localparam logic [5:0] c_addr_cnt    = 6'h04;
    localparam logic [5:0] c_addr_init   = 6'h08;
    localparam logic [5:0] c_addr_min    = 6'h0C;
    localparam logic [5:0] c_addr_max    = 6'h10;
    localparam logic [5:0] c_addr_match0 = 6'h14;
    localparam logic [5:0] c_addr_match1 = 6'h18;

    localparam int c_load_writes = 6;

endpackage

`default_nettype wire

// File: rtl/timer_seq_ctrl_rise_detect.sv
// ============================================================================
// Module      : rise_detect
// Description : Registers a level input and flags its 0->1 transitions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect (
    input  logic clk,
    input  logic rst_b,
    input  logic level,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= level;
        end
    end

    assign rise = level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/timer_seq_ctrl.sv
// ============================================================================
// Module      : timer_seq_ctrl
// Description : Programs a timer over its register bus, runs it for a number
//               of overflow periods, then stops it and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_seq_ctrl
    import timer_seq_pkg::*;
#(
    parameter int COUNTER_SIZE   = 32,
    parameter int CTRL_START_BIT = 0
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [COUNTER_SIZE-1:0] cfg_ctrl_i,
    input  logic [COUNTER_SIZE-1:0] cfg_init_i,
    input  logic [COUNTER_SIZE-1:0] cfg_min_i,
    input  logic [COUNTER_SIZE-1:0] cfg_max_i,
    input  logic [COUNTER_SIZE-1:0] cfg_match0_i,
    input  logic [COUNTER_SIZE-1:0] cfg_match1_i,
    input  logic [15:0]             num_periods_i,
    input  logic                    overflow_int_i,
    output logic [5:0]              tmr_addr_o,
    output logic                    tmr_wr_en_o,
    output logic                    tmr_mod_en_o,
    output logic [COUNTER_SIZE-1:0] tmr_wdata_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    aborted_o,
    output logic [15:0]             period_cnt_o
);

    localparam logic [COUNTER_SIZE-1:0] c_start_mask =
        {{(COUNTER_SIZE-1){1'b0}}, 1'b1} << CTRL_START_BIT;

    state_t                  r_state;
    logic [2:0]              r_idx;
    logic [COUNTER_SIZE-1:0] r_ctrl;
    logic [COUNTER_SIZE-1:0] r_init;
    logic [COUNTER_SIZE-1:0] r_min;
    logic [COUNTER_SIZE-1:0] r_max;
    logic [COUNTER_SIZE-1:0] r_match0;
    logic [COUNTER_SIZE-1:0] r_match1;
    logic [15:0]             r_num;

    logic                    w_rise;
    logic [15:0]             w_cnt_inc;
    logic                    w_last_edge;
    logic [5:0]              w_ld_addr;
    logic [COUNTER_SIZE-1:0] w_ld_data;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst_b (rst_b),
        .level (overflow_int_i),
        .rise  (w_rise)
    );

    assign w_cnt_inc   = period_cnt_o + 16'd1;
    assign w_last_edge = w_rise && (r_num != 16'd0) && (w_cnt_inc == r_num);

    // Write 0 (CTRL) is issued straight from the inputs on the start edge;
    // the remaining LOAD writes come from the shadow copies.
    always_comb begin
        w_ld_addr = 6'h00;
        w_ld_data = '0;
        case (r_idx)
            3'd1:    begin w_ld_addr = c_addr_min;    w_ld_data = r_min;    end
            3'd2:    begin w_ld_addr = c_addr_max;    w_ld_data = r_max;    end
            3'd3:    begin w_ld_addr = c_addr_match0; w_ld_data = r_match0; end
            3'd4:    begin w_ld_addr = c_addr_match1; w_ld_data = r_match1; end
            3'd5:    begin w_ld_addr = c_addr_init;   w_ld_data = r_init;   end
            default: begin w_ld_addr = 6'h00;         w_ld_data = '0;       end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= IDLE;
            r_idx        <= 3'd0;
            r_ctrl       <= '0;
            r_init       <= '0;
            r_min        <= '0;
            r_max        <= '0;
            r_match0     <= '0;
            r_match1     <= '0;
            r_num        <= 16'd0;
            tmr_addr_o   <= 6'h00;
            tmr_wr_en_o  <= 1'b0;
            tmr_mod_en_o <= 1'b0;
            tmr_wdata_o  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            aborted_o    <= 1'b0;
            period_cnt_o <= 16'd0;
        end else begin
            tmr_addr_o   <= 6'h00;
            tmr_wr_en_o  <= 1'b0;
            tmr_mod_en_o <= 1'b0;
            tmr_wdata_o  <= '0;
            done_o       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_ctrl       <= cfg_ctrl_i;
                        r_init       <= cfg_init_i;
                        r_min        <= cfg_min_i;
                        r_max        <= cfg_max_i;
                        r_match0     <= cfg_match0_i;
                        r_match1     <= cfg_match1_i;
                        r_num        <= num_periods_i;
                        period_cnt_o <= 16'd0;
                        aborted_o    <= 1'b0;
                        busy_o       <= 1'b1;
                        r_idx        <= 3'd1;
                        r_state      <= LOAD;
                        tmr_wr_en_o  <= 1'b1;
                        tmr_mod_en_o <= 1'b1;
                        tmr_addr_o   <= c_addr_ctrl;
                        tmr_wdata_o  <= cfg_ctrl_i & ~c_start_mask;
                    end
                end
                LOAD: begin
                    tmr_wr_en_o  <= 1'b1;
                    tmr_mod_en_o <= 1'b1;
                    if (abort_i) begin
                        aborted_o   <= 1'b1;
                        r_state     <= STOP;
                        tmr_addr_o  <= c_addr_ctrl;
                        tmr_wdata_o <= r_ctrl & ~c_start_mask;
                    end else if (r_idx == 3'(c_load_writes)) begin
                        r_state     <= ARM;
                        tmr_addr_o  <= c_addr_ctrl;
                        tmr_wdata_o <= r_ctrl | c_start_mask;
                    end else begin
                        r_idx       <= r_idx + 3'd1;
                        tmr_addr_o  <= w_ld_addr;
                        tmr_wdata_o <= w_ld_data;
                    end
                end
                ARM: begin
                    if (abort_i) begin
                        aborted_o    <= 1'b1;
                        r_state      <= STOP;
                        tmr_wr_en_o  <= 1'b1;
                        tmr_mod_en_o <= 1'b1;
                        tmr_addr_o   <= c_addr_ctrl;
                        tmr_wdata_o  <= r_ctrl & ~c_start_mask;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_rise) begin
                        period_cnt_o <= w_cnt_inc;
                    end
                    // An abort coinciding with the final edge still counts the edge.
                    if (abort_i || w_last_edge) begin
                        if (abort_i) begin
                            aborted_o <= 1'b1;
                        end
                        r_state      <= STOP;
                        tmr_wr_en_o  <= 1'b1;
                        tmr_mod_en_o <= 1'b1;
                        tmr_addr_o   <= c_addr_ctrl;
                        tmr_wdata_o  <= r_ctrl & ~c_start_mask;
                    end
                end
                STOP: begin
                    done_o  <= 1'b1;
                    r_state <= FIN;
                end
                FIN: begin
                    busy_o  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
